// File: rtl/digitron_scan_decoder_if.sv
// Scan-bus / readback bundle for digitron_scan_decoder.
// master = bench or driver side, slave = decoder.
interface digitron_scan_decoder_if;
  logic [7:0]  Seg_In;
  logic [5:0]  CS_In;
  logic [23:0] Hex_Out;
  logic        Frame_Done;
  logic        Seg_Err;
  logic        Stale;
  logic [5:0]  DP_Out;

  modport master (
    output Seg_In, CS_In,
    input  Hex_Out, Frame_Done, Seg_Err, Stale, DP_Out
  );

  modport slave (
    input  Seg_In, CS_In,
    output Hex_Out, Frame_Done, Seg_Err, Stale, DP_Out
  );
endinterface

// File: rtl/digitron_scan_decoder.sv
// Inverse decoder for a 6-digit multiplexed 7-segment scan bus; rebuilds the 24-bit value per frame.
// Optional decimal-point capture: define DIGITRON_DP_CAPTURE_EN.
module digitron_scan_decoder #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 11
) (
  input  logic                    CLK,
  input  logic                    RST,
  digitron_scan_decoder_if.slave  bus
);

`ifdef DIGITRON_DP_CAPTURE_EN
  localparam int unsigned SEG_W = 8;
`else
  localparam int unsigned SEG_W = 7;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_HOLD} state_e;

  function automatic logic one_cold(input logic [5:0] cs);
    return $countones(~cs) == 1;
  endfunction

  // Returns {known, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h3F: decode = {1'b1, 4'h0};
      7'h06: decode = {1'b1, 4'h1};
      7'h5B: decode = {1'b1, 4'h2};
      7'h4F: decode = {1'b1, 4'h3};
      7'h66: decode = {1'b1, 4'h4};
      7'h6D: decode = {1'b1, 4'h5};
      7'h7D: decode = {1'b1, 4'h6};
      7'h07: decode = {1'b1, 4'h7};
      7'h7F: decode = {1'b1, 4'h8};
      7'h6F: decode = {1'b1, 4'h9};
      7'h77: decode = {1'b1, 4'hA};
      7'h7C: decode = {1'b1, 4'hB};
      7'h39: decode = {1'b1, 4'hC};
      7'h5E: decode = {1'b1, 4'hD};
      7'h79: decode = {1'b1, 4'hE};
      7'h71: decode = {1'b1, 4'hF};
      default: decode = 5'b0;
    endcase
  endfunction

  logic [5:0]       cs_m_q, cs_m_d, cs_s_q, cs_s_d, cs_p_q, cs_p_d;
  logic [SEG_W-1:0] seg_m_q, seg_m_d, seg_s_q, seg_s_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      shadow_q, shadow_d, hex_q, hex_d;
  logic [5:0]       mask_q, mask_d;
  logic             frame_done_q, frame_done_d;
  logic             seg_err_q, seg_err_d;
  logic             stale_q, stale_d;
  logic             changed, cs_ok, capture, mask_full;
  logic [4:0]       dec;
`ifdef DIGITRON_DP_CAPTURE_EN
  logic [5:0]       dp_shadow_q, dp_shadow_d, dp_q, dp_d;
`else
  logic             unused_dp_in;
  assign unused_dp_in = bus.Seg_In[7];
`endif

  always_comb begin
    cs_m_d  = bus.CS_In;
    cs_s_d  = cs_m_q;
    cs_p_d  = cs_s_q;
    seg_m_d = bus.Seg_In[SEG_W-1:0];
    seg_s_d = seg_m_q;

    changed   = cs_s_q != cs_p_q;
    cs_ok     = one_cold(cs_s_q);
    mask_full = &mask_q;
    dec       = decode(seg_s_q[6:0]);

    // One counter serves both settle timing and stale detection.
    if (changed || (state_q == ST_IDLE && cs_ok))
      cnt_d = CNT_W'(1);
    else if (cnt_q != CNT_W'(TIMEOUT))
      cnt_d = cnt_q + CNT_W'(1);
    else
      cnt_d = cnt_q;
    stale_d = cnt_d == CNT_W'(TIMEOUT);

    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE:    if (cs_ok) state_d = ST_SETTLE;
      ST_SETTLE:
        if (changed)                      state_d = cs_ok ? ST_SETTLE : ST_IDLE;
        else if (cnt_d >= CNT_W'(SETTLE)) state_d = ST_CAPTURE;
      // A select change during the capture cycle aborts it rather than
      // writing the slot of a digit that never settled.
      ST_CAPTURE:
        if (changed) state_d = cs_ok ? ST_SETTLE : ST_IDLE;
        else begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      ST_HOLD:    if (changed) state_d = cs_ok ? ST_SETTLE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    frame_done_d = mask_full;
    hex_d        = mask_full ? shadow_q : hex_q;
    mask_d       = mask_full ? '0 : mask_q;
    shadow_d     = shadow_q;
    seg_err_d    = capture && !dec[4];
`ifdef DIGITRON_DP_CAPTURE_EN
    dp_shadow_d  = dp_shadow_q;
    dp_d         = mask_full ? dp_shadow_q : dp_q;
`endif
    if (capture && dec[4]) begin
      for (int unsigned i = 0; i < 6; i++) begin
        if (!cs_s_q[i]) begin
          shadow_d[i*4 +: 4] = dec[3:0];
          mask_d[i]          = 1'b1;
`ifdef DIGITRON_DP_CAPTURE_EN
          dp_shadow_d[i]     = seg_s_q[7];
`endif
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cs_m_q       <= '1;
      cs_s_q       <= '1;
      cs_p_q       <= '1;
      seg_m_q      <= '0;
      seg_s_q      <= '0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shadow_q     <= '0;
      mask_q       <= '0;
      hex_q        <= '0;
      frame_done_q <= 1'b0;
      seg_err_q    <= 1'b0;
      stale_q      <= 1'b0;
`ifdef DIGITRON_DP_CAPTURE_EN
      dp_shadow_q  <= '0;
      dp_q         <= '0;
`endif
    end else begin
      cs_m_q       <= cs_m_d;
      cs_s_q       <= cs_s_d;
      cs_p_q       <= cs_p_d;
      seg_m_q      <= seg_m_d;
      seg_s_q      <= seg_s_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      mask_q       <= mask_d;
      hex_q        <= hex_d;
      frame_done_q <= frame_done_d;
      seg_err_q    <= seg_err_d;
      stale_q      <= stale_d;
`ifdef DIGITRON_DP_CAPTURE_EN
      dp_shadow_q  <= dp_shadow_d;
      dp_q         <= dp_d;
`endif
    end
  end

  assign bus.Hex_Out    = hex_q;
  assign bus.Frame_Done = frame_done_q;
  assign bus.Seg_Err    = seg_err_q;
  assign bus.Stale      = stale_q;
`ifdef DIGITRON_DP_CAPTURE_EN
  assign bus.DP_Out     = dp_q;
`else
  assign bus.DP_Out     = '0;
`endif

endmodule

// File: doc/digitron_scan_decoder.md
Name: digitron_scan_decoder

Overview:
- Receive-side counterpart of the 6-digit multiplexed 7-segment scan driver.
- Samples the scan bus (segment lines plus active-low digit selects) and inverse-decodes each digit's segment pattern back to a hex nibble.
- Reassembles the 24-bit displayed value and presents it atomically once per complete scan frame.
- Used for on-board readback and self-check of display contents, and as a bench monitor.

Parameters:
- SETTLE, 4: consecutive synchronised cycles the select must stay unchanged before its segment pattern is captured.
- TIMEOUT, 1024: cycles without a select change before Stale asserts.
- CNT_W, 11: width of the settle/timeout counter; must hold TIMEOUT.

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous active-high reset
- Seg_In  input  8  segment lines, active-high; bit7 = dp, bits6:0 = g..a
- CS_In  input  6  digit selects, active-low one-cold; 6'b11_1110 = digit 0 (bits 3:0), 6'b01_1111 = digit 5 (bits 23:20)
- Hex_Out  output  24  last complete decoded frame
- Frame_Done  output  1  one-cycle pulse when Hex_Out updates
- Seg_Err  output  1  one-cycle pulse on an unrecognised segment pattern
- Stale  output  1  scan bus has stopped cycling
- DP_Out  output  6  decimal-point state per digit (see Optional Feature)

Behaviour:
- Reset: asynchronous.
  - Hex_Out=0, Frame_Done=0, Seg_Err=0, Stale=0, DP_Out=0.
  - Shadow register=0, captured mask=0, counter=0, state=IDLE.
  - Reset mid-frame discards partial captures.
- Input sync: Seg_In and CS_In each pass through 2 flops. All decisions use the synchronised values (cs_s, seg_s).
- Valid select: cs_s has exactly one zero bit. All other values (all-ones, multiple zeros) are invalid.
- FSM states:
  - IDLE: on a valid cs_s, go to SETTLE and load counter=1.
  - SETTLE: if cs_s differs from the previous cycle, reload counter=1 (go to IDLE if invalid). Otherwise increment; when counter reaches SETTLE, go to CAPTURE.
  - CAPTURE (1 cycle): decode seg_s[6:0], then go to HOLD.
  - HOLD: on any cs_s change, go to SETTLE if valid, else IDLE. Exactly one capture per select dwell.
- Decode table (seg_s[6:0] -> nibble):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, B:7C, C:39, D:5E, E:79, F:71
- Capture of a known pattern: write the nibble into the shadow slot of the selected digit and set that mask bit. A repeat digit within a frame overwrites its slot.
- Capture of an unknown pattern: Seg_Err pulses on the next clock; slot and mask are unchanged.
- Frame completion: when the mask reaches 6'b11_1111, on the next clock:
  - Hex_Out <= shadow,
  - Frame_Done=1 for one cycle,
  - mask cleared.
  - Seg_Err and Frame_Done are never set by the same capture.
- Latency: CS_In edge → 2 sync cycles + SETTLE cycles → CAPTURE → outputs register 1 cycle later.
- Stale:
  - Counter runs in every state while cs_s is unchanged and saturates at TIMEOUT.
  - Stale=1 while saturated.
  - Any cs_s change clears the count, and Stale drops on the following clock.
  - Hex_Out holds its value while Stale.

Optional Feature:
- Macro: DIGITRON_DP_CAPTURE_EN.
- Defined: each valid capture also writes seg_s[7] into a shadow dp bit for that digit. DP_Out updates from the shadow together with Hex_Out at Frame_Done. The decode ignores bit7 either way.
- Undefined: DP_Out is tied to 6'b0 and no dp storage is built.

Test Plan:
- Driver-style scan: each digit held 201 cycles, frame showing 24'h0003FF (digits 0..5 = F,F,3,0,0,0) → Frame_Done after the 6th capture, Hex_Out=24'h0003FF.
- Select glitch: CS changes to a new digit 2 cycles into the dwell, then holds → SETTLE restarts; one capture, for the new digit only.
- Seg_In[6:0]=7'h00 on digit 2 → Seg_Err pulse; no Frame_Done that frame; Hex_Out keeps its previous value.
- CS_In held at 6'b11_1110 for 1100 cycles → Stale=1 from about cycle 1024 (plus sync); the next select change clears it.
- RST asserted after 3 digits captured, then a full frame of 24'h123456 → Hex_Out=24'h123456 with no stale nibbles; Hex_Out=0 during reset.
- With DIGITRON_DP_CAPTURE_EN, bit7=1 on digit 4 only → DP_Out=6'b01_0000 at Frame_Done.
